// File: rtl/channelizer4_combiner.sv
// ---------------------------------------------------------------------------
// channelizer4_combiner
//
// Purpose:
//   4-to-1 channel combiner: merges four Avalon-ST sample streams (ready
//   latency 0) into one channel-tagged stream. Each input owns a 1-deep
//   holding register. A round-robin arbiter feeds a registered output stage
//   that honours downstream backpressure.
//
// Configuration:
//   COMBINER_STRICT_ORDER_EN - when defined, the arbiter is strict TDM: only
//   holder (rr_last+1) mod 4 may be granted, so the emission order is always
//   0,1,2,3,... When undefined, the arbiter is work-conserving round-robin.
//
// Ports:
//   clk                      system clock, rising edge
//   reset                    synchronous, active-high reset
//   in_data_1..4   [width]   sample data, inputs 1..4
//   in_error_1..4  [2]       error field, inputs 1..4
//   in_valid_1..4            sample valid, inputs 1..4
//   in_ready_1..4            holding register n is empty (registered)
//   out_data       [width]   selected sample
//   out_error      [2]       error field of the selected sample
//   out_channel    [2]       source tag, 0..3 = inputs 1..4
//   out_valid                output register holds a sample
//   out_ready                downstream accepts when high with out_valid
// ---------------------------------------------------------------------------
module channelizer4_combiner #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] in_data_1,
    input  logic [width-1:0] in_data_2,
    input  logic [width-1:0] in_data_3,
    input  logic [width-1:0] in_data_4,
    input  logic [1:0]       in_error_1,
    input  logic [1:0]       in_error_2,
    input  logic [1:0]       in_error_3,
    input  logic [1:0]       in_error_4,
    input  logic             in_valid_1,
    input  logic             in_valid_2,
    input  logic             in_valid_3,
    input  logic             in_valid_4,
    output logic             in_ready_1,
    output logic             in_ready_2,
    output logic             in_ready_3,
    output logic             in_ready_4,
    output logic [width-1:0] out_data,
    output logic [1:0]       out_error,
    output logic [1:0]       out_channel,
    output logic             out_valid,
    input  logic             out_ready
);

    // Inputs gathered into arrays so the per-channel logic can be looped.
    logic [width-1:0] in_data_a [4];
    logic [1:0]       in_err_a  [4];
    logic [3:0]       in_valid_a;

    assign in_data_a[0] = in_data_1;
    assign in_data_a[1] = in_data_2;
    assign in_data_a[2] = in_data_3;
    assign in_data_a[3] = in_data_4;
    assign in_err_a[0]  = in_error_1;
    assign in_err_a[1]  = in_error_2;
    assign in_err_a[2]  = in_error_3;
    assign in_err_a[3]  = in_error_4;
    assign in_valid_a   = {in_valid_4, in_valid_3, in_valid_2, in_valid_1};

    // Holding registers.
    logic [width-1:0] hold_data_q [4];
    logic [1:0]       hold_err_q  [4];
    logic [3:0]       hold_full_q, hold_full_d;
    logic [3:0]       capture;

    // Output stage and arbiter pointer.
    logic [width-1:0] out_data_q, out_data_d;
    logic [1:0]       out_error_q, out_error_d;
    logic [1:0]       out_channel_q, out_channel_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       rr_last_q, rr_last_d;

    // Arbiter result.
    logic             grant_vld;
    logic [1:0]       grant_idx;
    logic             load;

    // in_ready comes straight from a flop: no combinational path from out_ready.
    assign in_ready_1 = ~hold_full_q[0];
    assign in_ready_2 = ~hold_full_q[1];
    assign in_ready_3 = ~hold_full_q[2];
    assign in_ready_4 = ~hold_full_q[3];

    assign capture = in_valid_a & ~hold_full_q;
    assign load    = ~out_valid_q | out_ready;

    // NOTE: combinational blocks assign every output a default first, so no
    // path through the block can leave a signal unassigned and infer a latch.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
`ifdef COMBINER_STRICT_ORDER_EN
        // Strict TDM: only the next slot in sequence may be served.
        grant_idx = rr_last_q + 2'd1;
        grant_vld = hold_full_q[grant_idx];
`else
        // Scan from rr_last+1 upward; the 2-bit sum wraps 3->0 by itself.
        for (int k = 0; k < 4; k++) begin
            logic [1:0] idx;
            idx = rr_last_q + 2'(k + 1);
            if (!grant_vld && hold_full_q[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
`endif
    end

    always_comb begin
        out_data_d    = out_data_q;
        out_error_d   = out_error_q;
        out_channel_d = out_channel_q;
        out_valid_d   = out_valid_q;
        rr_last_d     = rr_last_q;
        hold_full_d   = hold_full_q;

        if (load) begin
            if (grant_vld) begin
                out_data_d    = hold_data_q[grant_idx];
                out_error_d   = hold_err_q[grant_idx];
                out_channel_d = grant_idx;
                out_valid_d   = 1'b1;
                rr_last_d     = grant_idx;
                hold_full_d[grant_idx] = 1'b0;
            end else begin
                // Metadata keeps its last value; only valid drops.
                out_valid_d = 1'b0;
            end
        end

        // A granted holder was full, so it cannot capture on the same edge;
        // set and clear never collide.
        hold_full_d = hold_full_d | capture;
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full_q   <= 4'b0000;
            out_data_q    <= '0;
            out_error_q   <= 2'b00;
            out_channel_q <= 2'd0;
            out_valid_q   <= 1'b0;
            rr_last_q     <= 2'd3;   // input 1 gets first priority
        end else begin
            hold_full_q   <= hold_full_d;
            out_data_q    <= out_data_d;
            out_error_q   <= out_error_d;
            out_channel_q <= out_channel_d;
            out_valid_q   <= out_valid_d;
            rr_last_q     <= rr_last_d;
        end
    end

    // NOTE: holding-register payload is not reset; it is only ever read while
    // its hold_full bit is set, and that bit is reset.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (capture[n]) begin
                hold_data_q[n] <= in_data_a[n];
                hold_err_q[n]  <= in_err_a[n];
            end
        end
    end

    assign out_data    = out_data_q;
    assign out_error   = out_error_q;
    assign out_channel = out_channel_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_channelizer4_combiner.sv
// ---------------------------------------------------------------------------
// tb_channelizer4_combiner
//
// Randomized stimulus against a behavioural model of the combiner. The model
// keeps four holding slots and a round-robin pointer as plain variables and
// applies the arbitration rule (first full slot after the last winner) each
// clock. Every emitted sample is pushed into a queue; a monitor on the falling
// edge pops and compares on each out_valid/out_ready handshake, and also
// compares the visible output register and in_ready flags every cycle.
// ---------------------------------------------------------------------------
module tb_channelizer4_combiner;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_data  [4];
    logic [1:0]   in_error [4];
    logic [3:0]   in_valid = 4'b0000;
    logic [3:0]   in_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_error;
    logic [1:0]   out_channel;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    channelizer4_combiner #(.width(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data_1  (in_data[0]),
        .in_data_2  (in_data[1]),
        .in_data_3  (in_data[2]),
        .in_data_4  (in_data[3]),
        .in_error_1 (in_error[0]),
        .in_error_2 (in_error[1]),
        .in_error_3 (in_error[2]),
        .in_error_4 (in_error[3]),
        .in_valid_1 (in_valid[0]),
        .in_valid_2 (in_valid[1]),
        .in_valid_3 (in_valid[2]),
        .in_valid_4 (in_valid[3]),
        .in_ready_1 (in_ready[0]),
        .in_ready_2 (in_ready[1]),
        .in_ready_3 (in_ready[2]),
        .in_ready_4 (in_ready[3]),
        .out_data   (out_data),
        .out_error  (out_error),
        .out_channel(out_channel),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_hdata [4];
    logic [1:0]   m_herr  [4];
    bit   [3:0]   m_full  = 4'b0000;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    logic [1:0]   m_err   = 2'b00;
    int           m_ch    = 0;
    int           m_rr    = 3;
    logic [W+3:0] exp_q [$];    // {channel, error, data}

    always @(posedge clk) begin
        if (reset) begin
            m_full  = 4'b0000;
            m_valid = 1'b0;
            m_data  = '0;
            m_err   = 2'b00;
            m_ch    = 0;
            m_rr    = 3;
            exp_q.delete();
        end else begin
            bit [3:0] full_before;
            int       g;
            full_before = m_full;
            g = -1;
            if (!m_valid || out_ready) begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_rr + k) % 4;
`ifdef COMBINER_STRICT_ORDER_EN
                    if (k == 1 && full_before[c]) g = c;
`else
                    if (g < 0 && full_before[c]) g = c;
`endif
                end
                if (g >= 0) begin
                    m_data    = m_hdata[g];
                    m_err     = m_herr[g];
                    m_ch      = g;
                    m_valid   = 1'b1;
                    m_full[g] = 1'b0;
                    m_rr      = g;
                    exp_q.push_back({2'(g), m_err, m_data});
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int n = 0; n < 4; n++) begin
                if (in_valid[n] && !full_before[n]) begin
                    m_hdata[n] = in_data[n];
                    m_herr[n]  = in_error[n];
                    m_full[n]  = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic [3:0] rdy_s = 4'b0000;   // in_ready as seen just before each edge
    int handshakes = 0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            rdy_s = in_ready;
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("out_data_reg", 64'(out_data), 64'(m_data));
            check("out_error_reg", 64'(out_error), 64'(m_err));
            check("out_channel_reg", 64'(out_channel), 64'(m_ch));
            for (int n = 0; n < 4; n++)
                check($sformatf("in_ready_%0d", n + 1), 64'(in_ready[n]), 64'(!m_full[n]));
            if (out_valid && out_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(out_valid), 64'(0));
                end else begin
                    logic [W+3:0] e;
                    e = exp_q.pop_front();
                    handshakes++;
                    check("sb_channel", 64'(out_channel), 64'(e[W+3:W+2]));
                    check("sb_error", 64'(out_error), 64'(e[W+1:W]));
                    check("sb_data", 64'(out_data), 64'(e[W-1:0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // One clock of traffic: inputs in `mask` offer a sample with probability
    // dens%, holding it until it is accepted; out_ready is high with rdy%.
    task automatic step(input bit [3:0] mask, input int dens, input int rdy);
        @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) begin
            if (in_valid[n] && rdy_s[n]) in_valid[n] = 1'b0;
            if (!in_valid[n] && mask[n] && ($urandom % 100) < dens) begin
                in_valid[n] = 1'b1;
                in_data[n]  = $urandom;
                in_error[n] = 2'($urandom);
            end
        end
        out_ready = ($urandom % 100) < rdy;
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin
            in_data[n]  = '0;
            in_error[n] = 2'b00;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Mixed traffic with mostly-ready sink.
        repeat (300) step(4'b1111, 50, 80);
        // Fill every holder under backpressure, then drain with all inputs busy.
        repeat (6)   step(4'b1111, 100, 0);
        repeat (40)  step(4'b1111, 100, 100);
        // Heavy backpressure.
        repeat (300) step(4'b1111, 70, 20);
        // Single streaming source (input 3).
        repeat (60)  step(4'b0100, 100, 100);
        // Mid-operation reset while traffic is live.
        repeat (20)  step(4'b1111, 90, 30);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (200) step(4'b1111, 60, 70);
        // Sparse traffic, two inputs.
        repeat (150) step(4'b0110, 40, 90);
        // Drain.
        for (int n = 0; n < 4; n++) in_valid[n] = 1'b0;
        repeat (20)  step(4'b0000, 0, 100);
        @(negedge clk);

`ifdef COMBINER_STRICT_ORDER_EN
        // Strict order may park samples behind an empty slot; only require
        // that the sink saw traffic.
        check("handshakes_seen", 64'(handshakes > 0), 64'(1));
`else
        check("queue_drained", 64'(exp_q.size()), 64'(0));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
